// File: rtl/impix_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module : impix_pio_pkg
// Brief  : Shared address map, edge-mode codes and bus widths for the PIO.
// Rev    : 1.0 - initial release
// ============================================================================
package impix_pio_pkg;

    localparam int ADDR_W = 3;
    localparam int BUS_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_INPUT    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/impix_pio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : impix_pio_sync_edge
// Brief  : Input synchroniser chain, previous-value register and edge detect.
// Rev    : 1.0 - initial release
// ============================================================================
module impix_pio_sync_edge
    import impix_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_async,
    output logic [DATA_WIDTH-1:0] o_sync,
    output logic [DATA_WIDTH-1:0] o_edge
);

    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] w_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign o_sync = w_s;

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign o_edge = ~w_s & r_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign o_edge = w_s ^ r_prev;
        end else begin : g_rise
            assign o_edge = w_s & ~r_prev;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/impix_system_pio_gen.sv
`default_nettype none
// ============================================================================
// Module : impix_system_pio_gen
// Brief  : Avalon-MM PIO with output register, edge capture and masked irq.
//          Build macro IMPIX_PIO_BITSET_EN enables OUTSET/OUTCLR at addr 4/5.
// Rev    : 1.0 - initial release
// ============================================================================
module impix_system_pio_gen
    import impix_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [BUS_W-1:0]      writedata,
    output logic [BUS_W-1:0]      readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_wd;
    logic [DATA_WIDTH-1:0] w_sync;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_cap_clr;
    logic [DATA_WIDTH-1:0] w_out_nxt;
    logic [BUS_W-1:0]      w_rd_val;
    logic                  w_unused_wd;

    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_cap;
    logic [BUS_W-1:0]      r_rdata;
    logic                  r_irq;

    assign w_wr        = chipselect & ~write_n;
    assign w_rd        = chipselect & ~read_n;
    assign w_wd        = writedata[DATA_WIDTH-1:0];
    assign w_unused_wd = &{1'b0, writedata};

    impix_pio_sync_edge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (reset),
        .i_async (in_port),
        .o_sync  (w_sync),
        .o_edge  (w_edge)
    );

    always_comb begin
        w_out_nxt = r_out;
        if (w_wr) begin
            case (address)
                ADDR_DATA:   w_out_nxt = w_wd;
`ifdef IMPIX_PIO_BITSET_EN
                ADDR_OUTSET: w_out_nxt = r_out | w_wd;
                ADDR_OUTCLR: w_out_nxt = r_out & ~w_wd;
`endif
                default:     w_out_nxt = r_out;
            endcase
        end
    end

    // A fresh edge is OR-ed in after the clear, so capture beats a same-cycle W1C.
    assign w_cap_clr = (w_wr && (address == ADDR_EDGE_CAP)) ? w_wd : '0;

    always_comb begin
        w_rd_val = '0;
        case (address)
            ADDR_DATA:     w_rd_val[DATA_WIDTH-1:0] = r_out;
            ADDR_INPUT:    w_rd_val[DATA_WIDTH-1:0] = w_sync;
            ADDR_IRQ_MASK: w_rd_val[DATA_WIDTH-1:0] = r_mask;
            ADDR_EDGE_CAP: w_rd_val[DATA_WIDTH-1:0] = r_cap;
            default:       w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= RESET_VALUE;
            r_mask  <= '0;
            r_cap   <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            if (w_wr && (address == ADDR_IRQ_MASK)) begin
                r_mask <= w_wd;
            end
            r_cap <= (r_cap & ~w_cap_clr) | w_edge;
            if (w_rd && !w_wr) begin
                r_rdata <= w_rd_val;
            end
            r_irq <= |(r_cap & r_mask);
        end
    end

    assign readdata = r_rdata;
    assign out_port = r_out;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_impix_system_pio_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_impix_system_pio_gen
// Brief  : Directed self-checking bench for impix_system_pio_gen.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_impix_system_pio_gen;

`ifdef IMPIX_PIO_BITSET_EN
    localparam bit BS = 1'b1;
`else
    localparam bit BS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_r, rd_a;
    logic [7:0]  out_r, out_a;
    logic        irq_r, irq_a;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    impix_system_pio_gen #(
        .DATA_WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut_r (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(rd_r), .in_port(in_port), .out_port(out_r), .irq(irq_r)
    );

    impix_system_pio_gen #(
        .DATA_WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(rd_a), .in_port(in_port), .out_port(out_a), .irq(irq_a)
    );

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Tasks are entered at a negedge and return at the negedge after the bus cycle.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    initial begin
        logic [7:0] o_set, o_clr;
        o_set = BS ? 8'hFF : 8'h0F;
        o_clr = BS ? 8'h7E : 8'h0F;
        vecs[0]  = '{1'b0, 3'd2, 32'h0,           8'hA5, 32'h0};
        vecs[1]  = '{1'b0, 3'd3, 32'h0,           8'hA5, 32'h0};
        vecs[2]  = '{1'b1, 3'd0, 32'h1234_563C,   8'h3C, 32'h0};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,           8'h3C, 32'h0000_003C};
        vecs[4]  = '{1'b0, 3'd1, 32'h0,           8'h3C, 32'h0};
        vecs[5]  = '{1'b1, 3'd2, 32'hAA,          8'h3C, 32'h0};
        vecs[6]  = '{1'b0, 3'd2, 32'h0,           8'h3C, 32'hAA};
        vecs[7]  = '{1'b1, 3'd0, 32'h0F,          8'h0F, 32'hAA};
        vecs[8]  = '{1'b1, 3'd4, 32'hF0,          o_set, 32'hAA};
        vecs[9]  = '{1'b1, 3'd5, 32'h81,          o_clr, 32'hAA};
        vecs[10] = '{1'b0, 3'd4, 32'h0,           o_clr, 32'h0};
        vecs[11] = '{1'b0, 3'd0, 32'h0,           o_clr, {24'h0, o_clr}};
        vecs[12] = '{1'b1, 3'd7, 32'hFF,          o_clr, {24'h0, o_clr}};
        vecs[13] = '{1'b0, 3'd6, 32'h0,           o_clr, 32'h0};
        vecs[14] = '{1'b1, 3'd2, 32'h0,           o_clr, 32'h0};
        vecs[15] = '{1'b0, 3'd2, 32'h0,           o_clr, 32'h0};

        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        read_n = 1'b1; writedata = '0; in_port = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_out", {24'h0, out_r}, 32'hA5);
        check("reset_irq", {31'h0, irq_r}, 32'h0);
        check("reset_rd",  rd_r, 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].data);
            else               bus_read(vecs[i].addr);
            check($sformatf("vec%0d_out", i), {24'h0, out_r}, {24'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_rd", i),  rd_r, vecs[i].exp_rd);
        end

        // Rising edge on bit 2, masked in: capture after 3 edges, irq one later.
        bus_write(3'd2, 32'h04);
        in_port[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("edge_irq_early", {31'h0, irq_r}, 32'h0);
        @(negedge clk);
        check("edge_irq_set", {31'h0, irq_r}, 32'h1);
        bus_read(3'd3);
        check("edge_cap_rd", rd_r, 32'h04);
        bus_read(3'd1);
        check("input_rd", rd_r, 32'h04);
        bus_write(3'd3, 32'h04);
        check("w1c_irq_hold", {31'h0, irq_r}, 32'h1);
        @(negedge clk);
        check("w1c_irq_clr", {31'h0, irq_r}, 32'h0);
        bus_read(3'd3);
        check("w1c_cap_clr", rd_r, 32'h0);

        // W1C lands on the same edge as the bit-1 edge pulse.
        bus_write(3'd2, 32'h00);
        in_port[1] = 1'b1;
        repeat (2) @(negedge clk);
        bus_write(3'd3, 32'h02);
        bus_read(3'd3);
        check("collide_cap_r", rd_r, 32'h02);
        check("collide_cap_a", rd_a, 32'h02);
        repeat (3) @(negedge clk);
        check("masked_irq", {31'h0, irq_r}, 32'h0);
        bus_write(3'd2, 32'h02);
        check("unmask_irq_early", {31'h0, irq_r}, 32'h0);
        @(negedge clk);
        check("unmask_irq_set", {31'h0, irq_r}, 32'h1);

        // Falling edge on bit 0: captured only by the any-edge instance.
        in_port[0] = 1'b1;
        repeat (4) @(negedge clk);
        bus_write(3'd3, 32'hFF);
        in_port[0] = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(3'd3);
        check("fall_cap_any",  rd_a, 32'h01);
        check("fall_cap_rise", rd_r, 32'h00);

        // Reset mid-operation, with a pulse on bit 7 while reset is held.
        bus_write(3'd2, 32'hFF);
        bus_write(3'd0, 32'h5A);
        in_port = 8'h00;
        repeat (4) @(negedge clk);
        check("pre_reset_irq_a", {31'h0, irq_a}, 32'h1);
        reset = 1'b1;
        in_port[7] = 1'b1;
        @(negedge clk);
        in_port[7] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst2_out",   {24'h0, out_a}, 32'hA5);
        check("rst2_irq_a", {31'h0, irq_a}, 32'h0);
        check("rst2_rd_a",  rd_a, 32'h0);
        bus_read(3'd3);
        check("rst2_cap_a", rd_a, 32'h0);
        check("rst2_cap_r", rd_r, 32'h0);
        bus_read(3'd2);
        check("rst2_mask", rd_a, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
